// File: rtl/forward_propagation_unit.sv
// Layer evaluation engine: each neuron is ReLU(bias + sum(w*x)) in signed
// fixed point, streamed out of network/trainer BRAM and written back.
module forward_propagation_unit #(
   parameter int INPUT_COUNT      = 3,
   parameter int OUTPUT_COUNT     = 1,
   parameter int NETWORK_ADDR_LEN = 5,
   parameter int TRAINER_ADDR_LEN = 4,
   parameter int DATA_LEN         = 32,
   parameter int FRAC_BITS        = 16
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        start_i,
   input  logic [NETWORK_ADDR_LEN-1:0] w_base_i,
   input  logic [NETWORK_ADDR_LEN-1:0] out_base_i,
   input  logic [TRAINER_ADDR_LEN-1:0] in_base_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        net_ena_o,
   output logic                        net_wr_ena_o,
   output logic [NETWORK_ADDR_LEN-1:0] net_addr_o,
   output logic [DATA_LEN-1:0]         net_wr_data_o,
   input  logic [DATA_LEN-1:0]         net_rd_data_i,
   output logic                        trn_ena_o,
   output logic [TRAINER_ADDR_LEN-1:0] trn_addr_o,
   input  logic [DATA_LEN-1:0]         trn_rd_data_i
);
   localparam int IW = (INPUT_COUNT > 1) ? $clog2(INPUT_COUNT) : 1;
   localparam int JW = (OUTPUT_COUNT > 1) ? $clog2(OUTPUT_COUNT) : 1;
   localparam int NA = NETWORK_ADDR_LEN;
   localparam int TA = TRAINER_ADDR_LEN;
   localparam int DW = DATA_LEN;
   localparam int PW = 2 * DW;
   localparam int SW = 2 * DW + 1;
   localparam logic signed [SW-1:0] MAXV =
      {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [SW-1:0] MINV =
      {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE, BIAS_RD, BIAS_LD, MAC_RD, MAC, ACT, WR, DONE
   } state_t;

   state_t state, state_nx;

   logic [IW-1:0]        i_q;
   logic [JW-1:0]        j_q;
   logic [NA-1:0]        blk_q;
   logic [NA-1:0]        out_q;
   logic [TA-1:0]        in_q;
   logic signed [DW-1:0] acc;
   logic [DW-1:0]        res;

   logic                 last_i;
   logic                 last_j;
   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] prod_sh;
   logic signed [SW-1:0] sum;
   logic [DW-1:0]        sum_sat;

   assign last_i = (i_q == IW'(INPUT_COUNT - 1));
   assign last_j = (j_q == JW'(OUTPUT_COUNT - 1));

   // Full-width product, then floor-shift back to the accumulator's scale
   always_comb begin
      prod = $signed({{DW{net_rd_data_i[DW-1]}}, net_rd_data_i})
           * $signed({{DW{trn_rd_data_i[DW-1]}}, trn_rd_data_i});
      prod_sh = prod >>> FRAC_BITS;
      sum = SW'(acc) + SW'(prod_sh);
      sum_sat = sum[DW-1:0];
      if (sum > MAXV)
         sum_sat = MAXV[DW-1:0];
      else if (sum < MINV)
         sum_sat = MINV[DW-1:0];
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state <= IDLE;
         i_q   <= '0;
         j_q   <= '0;
         blk_q <= '0;
         out_q <= '0;
         in_q  <= '0;
         acc   <= '0;
         res   <= '0;
      end else begin
         state <= state_nx;
         unique case (state)
            IDLE: begin
               if (start_i) begin
                  blk_q <= w_base_i;
                  out_q <= out_base_i;
                  in_q  <= in_base_i;
                  i_q   <= '0;
                  j_q   <= '0;
               end
            end
            BIAS_LD: acc <= net_rd_data_i;
            MAC: begin
               acc <= sum_sat;
               if (!last_i)
                  i_q <= i_q + IW'(1);
            end
            ACT: res <= acc[DW-1] ? '0 : acc;
            WR: begin
               if (!last_j) begin
                  j_q   <= j_q + JW'(1);
                  i_q   <= '0;
                  blk_q <= blk_q + NA'(INPUT_COUNT + 1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx      = state;
      busy_o        = (state != IDLE);
      done_o        = 1'b0;
      net_ena_o     = 1'b0;
      net_wr_ena_o  = 1'b0;
      net_addr_o    = '0;
      net_wr_data_o = '0;
      trn_ena_o     = 1'b0;
      trn_addr_o    = '0;
      unique case (state)
         IDLE: if (start_i) state_nx = BIAS_RD;
         BIAS_RD: begin
            net_ena_o  = 1'b1;
            net_addr_o = blk_q;
            state_nx   = BIAS_LD;
         end
         BIAS_LD: state_nx = MAC_RD;
         MAC_RD: begin
            net_ena_o  = 1'b1;
            net_addr_o = blk_q + NA'(i_q) + NA'(1);
            trn_ena_o  = 1'b1;
            trn_addr_o = in_q + TA'(i_q);
            state_nx   = MAC;
         end
         MAC: state_nx = last_i ? ACT : MAC_RD;
         ACT: state_nx = WR;
         WR: begin
            net_ena_o     = 1'b1;
            net_wr_ena_o  = 1'b1;
            net_addr_o    = out_q + NA'(j_q);
            net_wr_data_o = res;
            state_nx      = last_j ? DONE : BIAS_RD;
         end
         DONE: begin
            done_o   = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
endmodule
